jump_addr_sequencer: RTL and testbench

Control sequencer for the 16-bit jump-address register of the 8-bit core. On a decoded jump, it fetches the two operand bytes (high, then low) over the byte-wide memory read port and steers them into the jump register's high/low byte loads. It then issues a single PC load with either the assembled target (taken) or the fall-through address (not taken). It sits between the instruction decoder, the memory read port and the PC.

---
 rtl/jump_addr_sequencer.sv | 131 +++++++++++++
 tb/tb_jump_addr_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jump_addr_sequencer.sv
// Jump-address sequencer: fetches the two operand bytes of a jump (high, then low)
// into the jump register, then issues one PC load with the target or the fall-through.
module jump_addr_sequencer #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              cond_ok,
    input  logic [ADDR_W-1:0] pc,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_data,
    output logic              reg_high,
    output logic              reg_low,
    output logic [DATA_W-1:0] reg_data,
    input  logic [ADDR_W-1:0] jreg_q,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_value,
    output logic              taken,
    output logic              busy,
    output logic [2:0]        dbg_state
);

    // Handshake: mem_rd stays high with a stable mem_addr until a cycle with mem_ack=1;
    // mem_data is consumed in that same cycle and the request drops on the next edge.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_HI  = 3'd1,
        WR_HI  = 3'd2,
        RD_LO  = 3'd3,
        WR_LO  = 3'd4,
        COMMIT = 3'd5
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] base;
    logic [DATA_W-1:0] byte_q;
    logic              taken_flag;

    assign reg_data  = byte_q;
    assign dbg_state = state;

    // The jump register only settles on the edge that ends WR_LO, so the target is
    // picked up from jreg_q during COMMIT rather than registered ahead of time.
    assign pc_value = pc_load ? (taken_flag ? jreg_q : base + ADDR_W'(2)) : '0;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            base       <= '0;
            byte_q     <= '0;
            taken_flag <= 1'b0;
            mem_rd     <= 1'b0;
            mem_addr   <= '0;
            reg_high   <= 1'b0;
            reg_low    <= 1'b0;
            pc_load    <= 1'b0;
            taken      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base       <= pc;
                        taken_flag <= cond_ok;
                        busy       <= 1'b1;
                        if (cond_ok) begin
                            state    <= RD_HI;
                            mem_rd   <= 1'b1;
                            mem_addr <= pc;
                        end else begin
                            state   <= COMMIT;
                            pc_load <= 1'b1;
                            taken   <= 1'b0;
                        end
                    end
                end
                RD_HI: begin
                    if (mem_ack) begin
                        byte_q   <= mem_data;
                        mem_rd   <= 1'b0;
                        mem_addr <= '0;
                        reg_high <= 1'b1;
                        state    <= WR_HI;
                    end
                end
                WR_HI: begin
                    reg_high <= 1'b0;
                    mem_rd   <= 1'b1;
                    mem_addr <= base + ADDR_W'(1);
                    state    <= RD_LO;
                end
                RD_LO: begin
                    if (mem_ack) begin
                        byte_q   <= mem_data;
                        mem_rd   <= 1'b0;
                        mem_addr <= '0;
                        reg_low  <= 1'b1;
                        state    <= WR_LO;
                    end
                end
                WR_LO: begin
                    reg_low <= 1'b0;
                    pc_load <= 1'b1;
                    taken   <= taken_flag;
                    state   <= COMMIT;
                end
                COMMIT: begin
                    pc_load <= 1'b0;
                    taken   <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    mem_rd   <= 1'b0;
                    mem_addr <= '0;
                    reg_high <= 1'b0;
                    reg_low  <= 1'b0;
                    pc_load  <= 1'b0;
                    taken    <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jump_addr_sequencer.sv
// Bench for jump_addr_sequencer: a memory responder and jump register around the DUT,
// with a per-cycle event model of each jump compared against observed events.
module tb_jump_addr_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        cond_ok = 1'b0;
    logic [15:0] pc = '0;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_data = '0;
    logic        reg_high;
    logic        reg_low;
    logic [7:0]  reg_data;
    logic [15:0] jreg_q = '0;
    logic        pc_load;
    logic [15:0] pc_value;
    logic        taken;
    logic        busy;
    logic [2:0]  dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    // Event word: {cycle[7:0], kind[3:0], pad[10:0], value[16:0]}
    logic [39:0] exp_q[$];
    logic [39:0] obs_q[$];

    localparam logic [3:0] EV_READ = 4'd1, EV_HIGH = 4'd2, EV_LOW = 4'd3,
                           EV_PC = 4'd4, EV_BUSY = 4'd5, EV_TIMEOUT = 4'd15;

    jump_addr_sequencer #(.ADDR_W(16), .DATA_W(8)) dut (
        .clock(clock), .reset(reset), .start(start), .cond_ok(cond_ok), .pc(pc),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
        .reg_high(reg_high), .reg_low(reg_low), .reg_data(reg_data), .jreg_q(jreg_q),
        .pc_load(pc_load), .pc_value(pc_value), .taken(taken), .busy(busy),
        .dbg_state(dbg_state)
    );

    always #5 clock = ~clock;

    // Jump register outside the DUT: byte loads land on the clock edge.
    always @(posedge clock) begin
        if (reg_high) jreg_q[15:8] <= reg_data;
        if (reg_low)  jreg_q[7:0]  <= reg_data;
    end

    function automatic logic [39:0] ev(input int cyc, input logic [3:0] kind, input logic [16:0] val);
        return {8'(cyc), kind, 11'd0, val};
    endfunction

    // Reference: what each cycle of a jump should show, counted from the start cycle.
    function automatic void model_jump(input logic [15:0] p, input bit c, input logic [7:0] hi,
                                       input logic [7:0] lo, input int whi, input int wlo);
        logic [15:0] p1   = p + 16'd1;
        logic [15:0] fall = p + 16'd2;
        int last = c ? 5 + whi + wlo : 1;
        for (int k = 1; k <= last; k++) begin
            if (c && k <= 1 + whi) exp_q.push_back(ev(k, EV_READ, {1'b0, p}));
            if (c && k >= 3 + whi && k <= 3 + whi + wlo) exp_q.push_back(ev(k, EV_READ, {1'b0, p1}));
            if (c && k == 2 + whi) exp_q.push_back(ev(k, EV_HIGH, {9'd0, hi}));
            if (c && k == 4 + whi + wlo) exp_q.push_back(ev(k, EV_LOW, {9'd0, lo}));
            if (k == last) exp_q.push_back(ev(k, EV_PC, c ? {1'b1, hi, lo} : {1'b0, fall}));
            exp_q.push_back(ev(k, EV_BUSY, 17'd1));
        end
    endfunction

    // Driver + monitor; called at a falling edge, returns at the falling edge of the
    // cycle after pc_load. spur > 0 pulses start during that cycle of the sequence.
    task automatic drive_jump(input logic [15:0] p, input bit c, input logic [7:0] hi,
                              input logic [7:0] lo, input int whi, input int wlo, input int spur);
        int  cyc = 1;
        int  wait_cnt = 0;
        int  rd_idx = 0;
        bit  done = 0;
        start = 1'b1; cond_ok = c; pc = p;
        @(negedge clock);
        start = 1'b0; cond_ok = 1'($urandom); pc = 16'($urandom);
        while (!done && cyc < 60) begin
            mem_ack = 1'b0;
            mem_data = 8'($urandom);
            if (mem_rd === 1'b1) begin
                obs_q.push_back(ev(cyc, EV_READ, {1'b0, mem_addr}));
                if (wait_cnt == (rd_idx == 0 ? whi : wlo)) begin
                    mem_ack = 1'b1;
                    mem_data = (rd_idx == 0) ? hi : lo;
                    wait_cnt = 0;
                    rd_idx++;
                end else begin
                    wait_cnt++;
                end
            end
            if (reg_high === 1'b1) obs_q.push_back(ev(cyc, EV_HIGH, {9'd0, reg_data}));
            if (reg_low === 1'b1) obs_q.push_back(ev(cyc, EV_LOW, {9'd0, reg_data}));
            if (pc_load === 1'b1) begin
                obs_q.push_back(ev(cyc, EV_PC, {taken, pc_value}));
                done = 1;
            end
            if (busy === 1'b1) obs_q.push_back(ev(cyc, EV_BUSY, 17'd1));
            start = (cyc == spur);
            @(negedge clock);
            cyc++;
        end
        mem_ack = 1'b0;
        start = 1'b0;
        if (!done) obs_q.push_back(ev(cyc, EV_TIMEOUT, 17'd0));
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        n_checks++;
        if ({mem_rd, mem_addr, reg_high, reg_low, reg_data, pc_load, pc_value, taken, busy} !== '0)
            $display("FAIL reset_outputs: got rd=%b addr=%h hi=%b lo=%b data=%h pcl=%b pcv=%h tk=%b busy=%b, required all 0",
                     mem_rd, mem_addr, reg_high, reg_low, reg_data, pc_load, pc_value, taken, busy);
        else n_pass++;
        n_checks++;
        if (dbg_state !== 3'd0) $display("FAIL reset_state: got %0d required 0", dbg_state);
        else n_pass++;
        reset = 1'b1;
    endtask

    task automatic test_taken();
        model_jump(16'h1200, 1, 8'hAB, 8'hCD, 0, 0);
        drive_jump(16'h1200, 1, 8'hAB, 8'hCD, 0, 0, 0);
        n_checks++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL taken_count: got %0d events required %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL taken_ev%0d: got %h required %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_not_taken();
        model_jump(16'h3000, 0, 8'h00, 8'h00, 0, 0);
        drive_jump(16'h3000, 0, 8'h11, 8'h22, 0, 0, 0);
        n_checks++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL not_taken_count: got %0d events required %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL not_taken_ev%0d: got %h required %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        obs_q.delete(); exp_q.delete();
        n_checks++;
        if (busy !== 1'b0 || pc_load !== 1'b0) $display("FAIL not_taken_idle: got busy=%b pc_load=%b required 0 0", busy, pc_load);
        else n_pass++;
    endtask

    task automatic test_wait_states();
        model_jump(16'h4000, 1, 8'h5E, 8'hA7, 3, 1);
        drive_jump(16'h4000, 1, 8'h5E, 8'hA7, 3, 1, 0);
        n_checks++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL wait_count: got %0d events required %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL wait_ev%0d: got %h required %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_wrap();
        model_jump(16'hFFFF, 1, 8'h12, 8'h34, 0, 1);
        drive_jump(16'hFFFF, 1, 8'h12, 8'h34, 0, 1, 0);
        model_jump(16'hFFFF, 0, 8'h00, 8'h00, 0, 0);
        drive_jump(16'hFFFF, 0, 8'h00, 8'h00, 0, 0, 0);
        n_checks++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL wrap_count: got %0d events required %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL wrap_ev%0d: got %h required %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid();
        start = 1'b1; cond_ok = 1'b1; pc = 16'h5555;
        @(negedge clock);                       // cycle 1: RD_HI
        start = 1'b0; mem_ack = 1'b1; mem_data = 8'h77;
        @(negedge clock);                       // cycle 2: WR_HI
        mem_ack = 1'b0;
        @(negedge clock);                       // cycle 3: RD_LO
        n_checks++;
        if (mem_rd !== 1'b1 || mem_addr !== 16'h5556)
            $display("FAIL reset_mid_pre: got rd=%b addr=%h required 1 5556", mem_rd, mem_addr);
        else n_pass++;
        reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({mem_rd, mem_addr, reg_high, reg_low, reg_data, pc_load, pc_value, taken, busy} !== '0)
            $display("FAIL reset_mid_outputs: got rd=%b addr=%h hi=%b lo=%b data=%h pcl=%b pcv=%h tk=%b busy=%b, required all 0",
                     mem_rd, mem_addr, reg_high, reg_low, reg_data, pc_load, pc_value, taken, busy);
        else n_pass++;
        n_checks++;
        if (dbg_state !== 3'd0) $display("FAIL reset_mid_state: got %0d required 0", dbg_state);
        else n_pass++;
        reset = 1'b1; mem_ack = 1'b1; mem_data = 8'h99;
        @(negedge clock);
        mem_ack = 1'b0;
        @(negedge clock);
        n_checks++;
        if (mem_rd !== 1'b0 || reg_low !== 1'b0 || busy !== 1'b0 || pc_load !== 1'b0 || reg_data !== 8'h00)
            $display("FAIL reset_mid_late_ack: got rd=%b lo=%b busy=%b pcl=%b data=%h required 0 0 0 0 00",
                     mem_rd, reg_low, busy, pc_load, reg_data);
        else n_pass++;
        model_jump(16'h6000, 1, 8'hC3, 8'h3C, 1, 0);
        drive_jump(16'h6000, 1, 8'hC3, 8'h3C, 1, 0, 0);
        n_checks++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL reset_mid_count: got %0d events required %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL reset_mid_ev%0d: got %h required %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_spurious();
        model_jump(16'h7000, 1, 8'h81, 8'h3C, 0, 0);
        drive_jump(16'h7000, 1, 8'h81, 8'h3C, 0, 0, 0);
        mem_ack = 1'b1; mem_data = 8'h5A;
        @(negedge clock);
        mem_ack = 1'b0;
        n_checks++;
        if (mem_rd !== 1'b0 || busy !== 1'b0 || reg_high !== 1'b0 || reg_data !== 8'h3C)
            $display("FAIL spurious_ack: got rd=%b busy=%b hi=%b data=%h required 0 0 0 3c", mem_rd, busy, reg_high, reg_data);
        else n_pass++;
        model_jump(16'h7100, 1, 8'h24, 8'h42, 0, 2);
        drive_jump(16'h7100, 1, 8'h24, 8'h42, 0, 2, 2);
        n_checks++;
        if (busy !== 1'b0 || pc_load !== 1'b0) $display("FAIL spurious_start_idle: got busy=%b pc_load=%b required 0 0", busy, pc_load);
        else n_pass++;
        n_checks++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL spurious_count: got %0d events required %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL spurious_ev%0d: got %h required %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        obs_q.delete(); exp_q.delete();
    endtask

    // Consecutive jumps with no idle gap: each start lands in the cycle after COMMIT.
    task automatic test_back_to_back();
        for (int n = 0; n < 20; n++) begin
            logic [15:0] p  = 16'($urandom);
            bit          c  = ($urandom_range(0, 3) != 0);
            logic [7:0]  hi = 8'($urandom);
            logic [7:0]  lo = 8'($urandom);
            int          wh = $urandom_range(0, 3);
            int          wl = $urandom_range(0, 3);
            model_jump(p, c, hi, lo, wh, wl);
            drive_jump(p, c, hi, lo, wh, wl, 0);
        end
        n_checks++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL b2b_count: got %0d events required %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL b2b_ev%0d: got %h required %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        obs_q.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_taken();
        test_not_taken();
        test_wait_states();
        test_wrap();
        test_reset_mid();
        test_spurious();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
